// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : opcodes, sequencer state encoding and opcode helpers
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Only add/sub produce a meaningful carry/borrow from the ALU.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_rr_arbiter.sv
// ============================================================================
// alu_rr_arbiter : two-input round-robin arbiter with last-grant pointer
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module alu_rr_arbiter (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic last;
  logic pick;
  logic any_req;

  // On a tie the requester not served last wins; a lone requester always wins.
  always_comb begin
    any_req = |req;
    pick    = (req == 2'b11) ? ~last : req[1];
  end

  assign grant_id = pick;
  assign grant    = (enable && any_req) ? (pick ? 2'b10 : 2'b01) : 2'b00;

  // Reset value 1 lets requester 0 win the first tie.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last <= 1'b1;
    end else if (enable && any_req) begin
      last <= pick;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// alu_op_sequencer : shares one external ALU between two requesters and
//                    returns tagged results over a valid/ready handshake
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ALU_LAT = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_overflow,
  output logic [2:0]       alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow
);

  if ((ALU_LAT < 1) || (ALU_LAT > 15)) begin : g_bad_lat
    $error("alu_op_sequencer: ALU_LAT must be within 1..15");
  end

  localparam logic [3:0] LAST_CNT = 4'(ALU_LAT - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       op_id;
  logic [1:0] grant;
  logic       grant_id;
  logic       arb_en;

  assign arb_en = (state == ST_IDLE);

  alu_rr_arbiter u_arb (
    .clock    (clock),
    .reset_n  (reset_n),
    .req      ({req1_valid, req0_valid}),
    .enable   (arb_en),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Ready is only ever raised in IDLE because the arbiter is disabled elsewhere.
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // The latched operation registers drive the ALU directly, so they hold
  // their values through IDLE and RESP.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cnt          <= 4'd0;
      op_id        <= 1'b0;
      alu_sel      <= 3'b000;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_cin      <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            op_id   <= grant_id;
            alu_sel <= grant_id ? req1_op  : req0_op;
            alu_a   <= grant_id ? req1_a   : req0_a;
            alu_b   <= grant_id ? req1_b   : req0_b;
            alu_cin <= grant_id ? req1_cin : req0_cin;
            cnt     <= 4'd0;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt == LAST_CNT) begin
            rsp_result   <= alu_result;
            rsp_overflow <= is_arith(alu_sel) & alu_overflow;
            rsp_id       <= op_id;
            rsp_valid    <= 1'b1;
            cnt          <= 4'd0;
            state        <= ST_RESP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// tb_alu_op_sequencer : vector table, directed corner sequences and a
//                       randomized two-requester run against a reference model
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int checks = 0;
  int errors = 0;

  // Main DUT (ALU_LAT = 1)
  logic       req0_valid = 0, req1_valid = 0, req0_cin = 0, req1_cin = 0;
  logic [2:0] req0_op = 0, req1_op = 0;
  logic [7:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic       req0_ready, req1_ready;
  logic       rsp_valid, rsp_id, rsp_overflow;
  logic       rsp_ready = 1;
  logic [7:0] rsp_result;
  logic [2:0] alu_sel;
  logic [7:0] alu_a, alu_b, alu_result;
  logic       alu_cin, alu_overflow;

  // Second DUT (ALU_LAT = 3)
  logic       d3_req0_valid = 0, d3_req0_cin = 0;
  logic [2:0] d3_req0_op = 0;
  logic [7:0] d3_req0_a = 0, d3_req0_b = 0;
  logic       d3_req1_valid = 0, d3_req1_cin = 0;
  logic [2:0] d3_req1_op = 0;
  logic [7:0] d3_req1_a = 0, d3_req1_b = 0;
  logic       d3_req0_ready, d3_req1_ready;
  logic       d3_rsp_valid, d3_rsp_id, d3_rsp_overflow;
  logic       d3_rsp_ready = 1;
  logic [7:0] d3_rsp_result;
  logic [2:0] d3_alu_sel;
  logic [7:0] d3_alu_a, d3_alu_b, d3_alu_result;
  logic       d3_alu_cin, d3_alu_overflow;

  // Reference arithmetic: {overflow, result}
  function automatic logic [8:0] ref_op(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic cin);
    int s;
    logic [7:0] r;
    logic o;
    o = 1'b0;
    r = 8'h00;
    s = 0;
    case (op)
      3'd0: begin s = int'(a) + int'(b) + int'(cin); r = s[7:0]; o = (s > 255); end
      3'd1: begin s = int'(a) - int'(b); r = s[7:0]; o = (s < 0); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: r = a << 1;
      default: r = a >> 1;
    endcase
    return {o, r};
  endfunction

  // External ALU model; overflow is deliberately 1 for logic/shift ops.
  function automatic logic [8:0] bench_alu(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic cin);
    logic [8:0] v;
    v = ref_op(op, a, b, cin);
    if (op > 3'd1) v[8] = 1'b1;
    return v;
  endfunction

  assign {alu_overflow, alu_result}       = bench_alu(alu_sel, alu_a, alu_b, alu_cin);
  assign {d3_alu_overflow, d3_alu_result} = bench_alu(d3_alu_sel, d3_alu_a, d3_alu_b, d3_alu_cin);

  alu_op_sequencer #(.WIDTH(8), .ALU_LAT(1)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_overflow(alu_overflow)
  );

  alu_op_sequencer #(.WIDTH(8), .ALU_LAT(3)) dut3 (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(d3_req0_valid), .req0_ready(d3_req0_ready), .req0_op(d3_req0_op),
    .req0_a(d3_req0_a), .req0_b(d3_req0_b), .req0_cin(d3_req0_cin),
    .req1_valid(d3_req1_valid), .req1_ready(d3_req1_ready), .req1_op(d3_req1_op),
    .req1_a(d3_req1_a), .req1_b(d3_req1_b), .req1_cin(d3_req1_cin),
    .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready), .rsp_id(d3_rsp_id),
    .rsp_result(d3_rsp_result), .rsp_overflow(d3_rsp_overflow),
    .alu_sel(d3_alu_sel), .alu_a(d3_alu_a), .alu_b(d3_alu_b), .alu_cin(d3_alu_cin),
    .alu_result(d3_alu_result), .alu_overflow(d3_alu_overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int id, input logic v, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b, input logic cin);
    if (id == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_cin = cin;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_cin = cin;
    end
  endtask

  function automatic logic rdy(input int id);
    return (id == 0) ? req0_ready : req1_ready;
  endfunction

  task automatic wait_ready(input int id, input string name, output int t);
    int g;
    g = 0;
    @(negedge clock);
    while (!rdy(id) && g < 50) begin
      @(negedge clock);
      g++;
    end
    chk({name, "_ready"}, 32'(rdy(id)), 32'd1);
    t = cyc;
  endtask

  task automatic wait_rsp(input logic id, input logic [7:0] res, input logic ovf,
                          input int t_acc, input string name);
    int g;
    g = 0;
    @(negedge clock);
    while (!rsp_valid && g < 50) begin
      @(negedge clock);
      g++;
    end
    chk({name, "_lat"}, 32'(cyc - t_acc), 32'd2);
    chk({name, "_id"}, 32'(rsp_id), 32'(id));
    chk({name, "_res"}, 32'(rsp_result), 32'(res));
    chk({name, "_ovf"}, 32'(rsp_overflow), 32'(ovf));
  endtask

  typedef struct {
    int         id;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] res;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic       id;
    logic [7:0] res;
    logic       ovf;
    int         cyc;
  } exp_t;

  logic done0 = 0, done1 = 0, mon_done = 0;

  task automatic drive_rand(input int id, input int n);
    int g;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
      set_req(id, 1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
              1'($urandom_range(0, 1)));
      g = 0;
      @(negedge clock);
      while (!rdy(id) && g < 300) begin
        @(negedge clock);
        g++;
      end
      if (!rdy(id)) begin
        checks++;
        errors++;
        $display("FAIL rand_drv%0d: ready 0 after %0d cycles, required 1", id, g);
      end
      @(posedge clock);
      #1;
      set_req(id, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
    end
  endtask

  task automatic monitor(input logic last_init);
    exp_t       q[$];
    exp_t       e;
    logic [8:0] r;
    logic       last;
    logic       exp_w;
    logic       prev_v;
    logic [9:0] prev_f;
    int         budget;
    last   = last_init;
    prev_v = 1'b0;
    prev_f = '0;
    budget = 0;
    while (!(done0 && done1 && q.size() == 0) && budget < 20000) begin
      @(negedge clock);
      budget++;
      if (req0_ready && req1_ready) chk("rand_onehot", 32'd3, 32'd1);
      if (req0_ready || req1_ready) begin
        exp_w = (req0_valid && req1_valid) ? ~last : req1_valid;
        chk("rand_grant", 32'(req1_ready), 32'(exp_w));
        chk("rand_accept_busy", 32'(q.size()), 32'd0);
        last = req1_ready;
        r = req1_ready ? ref_op(req1_op, req1_a, req1_b, req1_cin)
                       : ref_op(req0_op, req0_a, req0_b, req0_cin);
        e.id = req1_ready; e.res = r[7:0]; e.ovf = r[8]; e.cyc = cyc;
        q.push_back(e);
      end else if (q.size() == 0 && (req0_valid || req1_valid)) begin
        chk("rand_idle_grant", 32'd0, 32'd1);
      end
      if (rsp_valid) begin
        if (q.size() == 0) begin
          chk("rand_spurious_rsp", 32'd1, 32'd0);
        end else begin
          if (!prev_v) chk("rand_lat", 32'(cyc - q[0].cyc), 32'd2);
          else chk("rand_stable", 32'({rsp_id, rsp_overflow, rsp_result}), 32'(prev_f));
          if (rsp_ready) begin
            chk("rand_rsp", 32'({rsp_id, rsp_overflow, rsp_result}),
                32'({q[0].id, q[0].ovf, q[0].res}));
            void'(q.pop_front());
            prev_v = 1'b0;
          end else begin
            prev_v = 1'b1;
            prev_f = {rsp_id, rsp_overflow, rsp_result};
          end
        end
      end else begin
        if (prev_v) chk("rand_valid_dropped", 32'd0, 32'd1);
        prev_v = 1'b0;
      end
    end
    if (budget >= 20000) chk("rand_timeout", 32'(q.size()), 32'd0);
    mon_done = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    int t, t2;
    vecs[0] = '{0, OP_ADD, 8'h01, 8'hFF, 1'b0, 8'h00, 1'b1};
    vecs[1] = '{0, OP_SUB, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
    vecs[2] = '{1, OP_XOR, 8'hA0, 8'h0F, 1'b0, 8'hAF, 1'b0};
    vecs[3] = '{0, OP_AND, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0};
    vecs[4] = '{1, OP_OR,  8'h0F, 8'h30, 1'b0, 8'h3F, 1'b0};
    vecs[5] = '{0, OP_NOT, 8'hA5, 8'h00, 1'b0, 8'h5A, 1'b0};
    vecs[6] = '{1, OP_SHL, 8'h81, 8'h00, 1'b0, 8'h02, 1'b0};
    vecs[7] = '{0, OP_SHR, 8'h81, 8'h00, 1'b0, 8'h40, 1'b0};
    vecs[8] = '{0, OP_SUB, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
    vecs[9] = '{1, OP_ADD, 8'h7F, 8'h80, 1'b1, 8'h00, 1'b1};

    #22 reset_n = 1'b1;
    @(negedge clock);
    chk("reset_outputs", 32'({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result,
                              rsp_overflow, alu_sel, alu_a, alu_b, alu_cin}), 32'd0);

    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      set_req(vecs[i].id, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_ready(vecs[i].id, $sformatf("vec%0d", i), t);
      @(posedge clock); #1;
      set_req(vecs[i].id, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
      wait_rsp(1'(vecs[i].id), vecs[i].res, vecs[i].ovf, t, $sformatf("vec%0d", i));
    end

    // Ties: last grant was requester 1, so requester 0 goes first.
    @(posedge clock); #1;
    set_req(0, 1'b1, OP_SUB, 8'h05, 8'h03, 1'b0);
    set_req(1, 1'b1, OP_XOR, 8'hA0, 8'h0F, 1'b0);
    wait_ready(0, "tie1", t);
    chk("tie1_other", 32'(req1_ready), 32'd0);
    @(posedge clock); #1; req0_valid = 1'b0;
    wait_rsp(1'b0, 8'h02, 1'b0, t, "tie1");
    wait_ready(1, "tie2", t);
    @(posedge clock); #1; req1_valid = 1'b0;
    wait_rsp(1'b1, 8'hAF, 1'b0, t, "tie2");
    @(posedge clock); #1;
    set_req(0, 1'b1, OP_SUB, 8'h05, 8'h03, 1'b0);
    set_req(1, 1'b1, OP_AND, 8'hFF, 8'h0F, 1'b0);
    wait_ready(0, "tie3", t);
    chk("tie3_other", 32'(req1_ready), 32'd0);
    @(posedge clock); #1; req0_valid = 1'b0;
    wait_rsp(1'b0, 8'h02, 1'b0, t, "tie3");
    wait_ready(1, "tie4", t);
    @(posedge clock); #1; req1_valid = 1'b0;
    wait_rsp(1'b1, 8'h0F, 1'b0, t, "tie4");

    // Backpressure holds RESP and blocks a waiting requester.
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    set_req(0, 1'b1, OP_AND, 8'hF0, 8'h3C, 1'b0);
    wait_ready(0, "bp", t);
    @(posedge clock); #1;
    set_req(0, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
    set_req(1, 1'b1, OP_OR, 8'h0F, 8'h30, 1'b0);
    wait_rsp(1'b0, 8'h30, 1'b0, t, "bp");
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk($sformatf("bp_hold%0d", k), 32'({rsp_valid, rsp_id, rsp_overflow, rsp_result}),
          32'({1'b1, 1'b0, 1'b0, 8'h30}));
      chk($sformatf("bp_block%0d", k), 32'(req1_ready), 32'd0);
    end
    @(posedge clock); #1; rsp_ready = 1'b1;
    @(negedge clock);
    chk("bp_release_block", 32'(req1_ready), 32'd0);
    t2 = cyc;
    wait_ready(1, "bp_next", t);
    chk("bp_next_cycle", 32'(t - t2), 32'd1);
    @(posedge clock); #1; req1_valid = 1'b0;
    wait_rsp(1'b1, 8'h3F, 1'b0, t, "bp_next");

    // Async reset in the middle of EXEC drops the operation.
    @(posedge clock); #1;
    set_req(0, 1'b1, OP_ADD, 8'h10, 8'h20, 1'b0);
    wait_ready(0, "rst_acc", t);
    @(posedge clock); #2;
    req0_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_async", 32'({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result,
                          rsp_overflow, alu_sel, alu_a, alu_b, alu_cin}), 32'd0);
    @(negedge clock);
    @(posedge clock); #2; reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk($sformatf("rst_no_stale%0d", k), 32'(rsp_valid), 32'd0);
    end
    @(posedge clock); #1;
    set_req(0, 1'b1, OP_AND, 8'hF0, 8'h3C, 1'b0);
    set_req(1, 1'b1, OP_OR, 8'h0F, 8'h30, 1'b0);
    wait_ready(0, "rst_tie", t);
    chk("rst_tie_other", 32'(req1_ready), 32'd0);
    @(posedge clock); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(1'b0, 8'h30, 1'b0, t, "rst_tie");

    // ALU_LAT = 3 instance: operands held three cycles, response at t+4.
    @(posedge clock); #1;
    d3_req0_valid = 1'b1; d3_req0_op = OP_ADD; d3_req0_a = 8'h22; d3_req0_b = 8'h11;
    d3_req0_cin = 1'b1;
    @(negedge clock);
    chk("lat3_ready", 32'(d3_req0_ready), 32'd1);
    @(posedge clock); #1; d3_req0_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      chk($sformatf("lat3_alu%0d", k), 32'({d3_alu_sel, d3_alu_a, d3_alu_b, d3_alu_cin}),
          32'({OP_ADD, 8'h22, 8'h11, 1'b1}));
      chk($sformatf("lat3_novalid%0d", k), 32'(d3_rsp_valid), 32'd0);
    end
    @(negedge clock);
    chk("lat3_rsp", 32'({d3_rsp_valid, d3_rsp_id, d3_rsp_overflow, d3_rsp_result}),
        32'({1'b1, 1'b0, 1'b0, 8'h34}));

    // Randomized run; last grant before this point was requester 0.
    fork
      begin drive_rand(0, 40); done0 = 1; end
      begin drive_rand(1, 40); done1 = 1; end
      begin
        while (!mon_done) begin
          @(posedge clock); #1;
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
        rsp_ready = 1'b1;
      end
      monitor(1'b0);
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
